// File: rtl/spi_tx_pkg.sv
// Shared types for the SPI TX chip-select scheduler.
// FSM state encoding and index-width helper.
package spi_tx_pkg;

    typedef enum logic [1:0] {
        ARB = 2'd0,
        RUN = 2'd1,
        GAP = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set req bit at or
// above rr, wrapping modulo N_REQ.
module spi_rr_pick
    import spi_tx_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SW-1:0]    rr,
    output logic             vld,
    output logic [SW-1:0]    idx
);

    logic [SW-1:0] j;

    // Scan from the farthest offset down so the nearest one wins.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        j   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = SW'((int'(rr) + i) % N_REQ);
            if (req[j]) begin
                vld = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/spi_tx_sched.sv
// Round-robin scheduler for a shared SPI TX CS sequencer.
// Optional RUN timeout: define SPI_TX_SCHED_TIMEOUT_EN.
module spi_tx_sched
    import spi_tx_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int SPI0_2 = 32,
    parameter int GAP_W  = 8,
    parameter int TO_W   = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*SPI0_2-1:0] del_csn_cfg,
    input  logic [N_REQ*SPI0_2-1:0] del_csp_cfg,
    input  logic [GAP_W-1:0]        gap_cyc,
    input  logic                    csn_cmpt,
    output logic                    csn_en,
    output logic [SPI0_2-1:0]       del_csn,
    output logic [SPI0_2-1:0]       del_csp,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [idx_w(N_REQ)-1:0] sel,
`ifdef SPI_TX_SCHED_TIMEOUT_EN
    input  logic [TO_W-1:0]         timeout_cyc,
    output logic [N_REQ-1:0]        err,
`endif
    output logic                    busy
);

    localparam int SW = idx_w(N_REQ);

    state_t           state;
    logic [SW-1:0]    rr;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_ld;
    logic [SW-1:0]    rr_nxt;
    logic             pick_vld;
    logic [SW-1:0]    pick_idx;
    logic             fin_ok;
    logic             fin_to;

    spi_rr_pick #(
        .N_REQ (N_REQ),
        .SW    (SW)
    ) u_pick (
        .req (req),
        .rr  (rr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    // A zero gap still yields one low-enable cycle for the sequencer.
    assign gap_ld = (gap_cyc == '0) ? GAP_W'(1) : gap_cyc;
    assign rr_nxt = (sel == SW'(N_REQ - 1)) ? '0 : sel + SW'(1);
    assign busy   = (state != ARB);
    assign fin_ok = csn_cmpt;

`ifdef SPI_TX_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // Fires on the edge that closes the timeout_cyc-th RUN cycle.
    assign to_hit = ({1'b0, to_cnt} + (TO_W+1)'(1)) == {1'b0, timeout_cyc};
    assign fin_to = !csn_cmpt && (timeout_cyc != '0) && to_hit;
`else
    assign fin_to = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB;
            rr      <= '0;
            sel     <= '0;
            gnt     <= '0;
            done    <= '0;
            csn_en  <= 1'b0;
            del_csn <= '0;
            del_csp <= '0;
            gap_cnt <= '0;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
            err     <= '0;
            to_cnt  <= '0;
`endif
        end else begin
            done <= '0;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
            err  <= '0;
`endif
            case (state)
                ARB: begin
                    if (pick_vld) begin
                        sel     <= pick_idx;
                        gnt     <= N_REQ'(1) << pick_idx;
                        del_csn <= del_csn_cfg[int'(pick_idx)*SPI0_2 +: SPI0_2];
                        del_csp <= del_csp_cfg[int'(pick_idx)*SPI0_2 +: SPI0_2];
                        csn_en  <= 1'b1;
                        state   <= RUN;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
                end
                RUN: begin
                    if (fin_ok || fin_to) begin
                        csn_en  <= 1'b0;
                        gnt     <= '0;
                        rr      <= rr_nxt;
                        gap_cnt <= gap_ld;
                        state   <= GAP;
                        if (fin_ok) begin
                            done[sel] <= 1'b1;
                        end
`ifdef SPI_TX_SCHED_TIMEOUT_EN
                        else begin
                            err[sel] <= 1'b1;
                        end
`endif
                    end
`ifdef SPI_TX_SCHED_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        state <= ARB;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_sched.sv
// Directed self-checking bench for spi_tx_sched (N_REQ=4).
// Timeout scenario runs only with SPI_TX_SCHED_TIMEOUT_EN.
module tb_spi_tx_sched;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int GW = 8;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] del_csn_cfg;
    logic [N*DW-1:0] del_csp_cfg;
    logic [GW-1:0] gap_cyc;
    logic          csn_cmpt;
    logic          csn_en;
    logic [DW-1:0] del_csn;
    logic [DW-1:0] del_csp;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic [1:0]    sel;
    logic          busy;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
    logic [TW-1:0] timeout_cyc;
    logic [N-1:0]  err;
`endif

    int checks   = 0;
    int failures = 0;

    spi_tx_sched #(
        .N_REQ  (N),
        .SPI0_2 (DW),
        .GAP_W  (GW),
        .TO_W   (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .del_csn_cfg (del_csn_cfg),
        .del_csp_cfg (del_csp_cfg),
        .gap_cyc     (gap_cyc),
        .csn_cmpt    (csn_cmpt),
        .csn_en      (csn_en),
        .del_csn     (del_csn),
        .del_csp     (del_csp),
        .gnt         (gnt),
        .done        (done),
        .sel         (sel),
`ifdef SPI_TX_SCHED_TIMEOUT_EN
        .timeout_cyc (timeout_cyc),
        .err         (err),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input string nm);
        int n = 0;
        while (csn_en !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (csn_en !== 1'b1) begin
            failures++;
            $display("FAIL %s: csn_en never rose (got %b, want 1)", nm, csn_en);
        end
    endtask

    task automatic finish_tx();
        int n = 0;
        csn_cmpt = 1'b1;
        step();
        csn_cmpt = 1'b0;
        req = '0;
        while (busy !== 1'b0 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (csn_en !== 1'b0) begin
            failures++; $display("FAIL reset_csn_en: got %b want 0", csn_en);
        end
        checks++;
        if (gnt !== 4'b0000) begin
            failures++; $display("FAIL reset_gnt: got %b want 0000", gnt);
        end
        checks++;
        if (done !== 4'b0000) begin
            failures++; $display("FAIL reset_done: got %b want 0000", done);
        end
        checks++;
        if (sel !== 2'd0) begin
            failures++; $display("FAIL reset_sel: got %0d want 0", sel);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (del_csn !== 32'd0 || del_csp !== 32'd0) begin
            failures++;
            $display("FAIL reset_del: got %0d/%0d want 0/0", del_csn, del_csp);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int bad = 0;
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100) begin
            failures++; $display("FAIL single_gnt: got %b want 0100", gnt);
        end
        checks++;
        if (sel !== 2'd2) begin
            failures++; $display("FAIL single_sel: got %0d want 2", sel);
        end
        checks++;
        if (del_csn !== 32'd5 || del_csp !== 32'd7) begin
            failures++;
            $display("FAIL single_del: got %0d/%0d want 5/7", del_csn, del_csp);
        end
        checks++;
        if (csn_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_en: got en=%b busy=%b want 1/1", csn_en, busy);
        end
        for (int i = 0; i < 18; i++) begin
            step();
            if (done !== 4'b0000 || csn_en !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL single_hold: %0d bad cycles, want 0", bad);
        end
        csn_cmpt = 1'b1;
        step();
        csn_cmpt = 1'b0;
        checks++;
        if (done !== 4'b0100 || csn_en !== 1'b0 || gnt !== 4'b0000) begin
            failures++;
            $display("FAIL single_done: got done=%b en=%b gnt=%b want 0100/0/0000",
                     done, csn_en, gnt);
        end
        req = '0;
        step();
        checks++;
        if (done !== 4'b0000) begin
            failures++; $display("FAIL single_done_pulse: got %b want 0000", done);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int e;
        logic [N-1:0] oh;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = exp_order[k];
            oh = 4'b0001 << e;
            wait_en("rr_wait");
            checks++;
            if (sel !== 2'(e) || gnt !== oh) begin
                failures++;
                $display("FAIL rr_grant%0d: got sel=%0d gnt=%b want sel=%0d gnt=%b",
                         k, sel, gnt, e, oh);
            end
            for (int i = 0; i < 3; i++) step();
            csn_cmpt = 1'b1;
            step();
            csn_cmpt = 1'b0;
            checks++;
            if (done !== oh) begin
                failures++;
                $display("FAIL rr_done%0d: got %b want %b", k, done, oh);
            end
            req[e] = 1'b0;
            step();
            step();
            if (k < 4) req[e] = 1'b1;
        end
        req = '0;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_gap();
        logic [GW-1:0] gv [2] = '{8'd3, 8'd0};
        int want [2] = '{3, 1};
        int n;
        req = 4'b0001;
        wait_en("gap_wait0");
        for (int g = 0; g < 2; g++) begin
            gap_cyc = gv[g];
            csn_cmpt = 1'b1;
            step();
            csn_cmpt = 1'b0;
            req = (g == 0) ? 4'b0010 : 4'b0100;
            n = 0;
            step();
            while (csn_en !== 1'b1 && n < 40) begin
                n++;
                step();
            end
            checks++;
            if (n != want[g]) begin
                failures++;
                $display("FAIL gap%0d: got %0d low cycles want %0d",
                         gv[g], n, want[g]);
            end
        end
        gap_cyc = 8'd2;
        finish_tx();
    endtask

    task automatic test_drop();
        req = 4'b0010;
        wait_en("drop_wait");
        checks++;
        if (sel !== 2'd1) begin
            failures++; $display("FAIL drop_sel: got %0d want 1", sel);
        end
        step();
        req = 4'b0000;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (csn_en !== 1'b1 || gnt !== 4'b0010) begin
            failures++;
            $display("FAIL drop_hold: got en=%b gnt=%b want 1/0010", csn_en, gnt);
        end
        csn_cmpt = 1'b1;
        step();
        csn_cmpt = 1'b0;
        checks++;
        if (done !== 4'b0010) begin
            failures++; $display("FAIL drop_done: got %b want 0010", done);
        end
        for (int i = 0; i < 5; i++) step();
        csn_cmpt = 1'b1;
        step();
        csn_cmpt = 1'b0;
        step();
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0 || csn_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_cmpt: got done=%b busy=%b en=%b want 0000/0/0",
                     done, busy, csn_en);
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b1000;
        wait_en("rstmid_wait");
        checks++;
        if (sel !== 2'd3) begin
            failures++; $display("FAIL rstmid_sel: got %0d want 3", sel);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (csn_en !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000 ||
            sel !== 2'd0 || busy !== 1'b0 || del_csn !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_out: got en=%b gnt=%b done=%b sel=%0d busy=%b want all 0",
                     csn_en, gnt, done, sel, busy);
        end
        rst = 1'b0;
        req = 4'b1001;
        step();
        checks++;
        if (sel !== 2'd0 || gnt !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_next: got sel=%0d gnt=%b want 0/0001", sel, gnt);
        end
        finish_tx();
    endtask

`ifdef SPI_TX_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int bad = 0;
        timeout_cyc = 24'd10;
        req = 4'b0100;
        wait_en("to_wait");
        for (int i = 1; i < 10; i++) begin
            step();
            if (err !== 4'b0000 || csn_en !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL to_early: %0d bad cycles want 0", bad);
        end
        step();
        checks++;
        if (err !== 4'b0100 || csn_en !== 1'b0 || done !== 4'b0000) begin
            failures++;
            $display("FAIL to_err: got err=%b en=%b done=%b want 0100/0/0000",
                     err, csn_en, done);
        end
        req = 4'b1100;
        wait_en("to_next_wait");
        checks++;
        if (sel !== 2'd3) begin
            failures++; $display("FAIL to_next: got sel=%0d want 3", sel);
        end
        timeout_cyc = 24'd0;
        finish_tx();
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = '0;
        csn_cmpt = 1'b0;
        gap_cyc = 8'd2;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
        timeout_cyc = '0;
`endif
        for (int i = 0; i < N; i++) begin
            del_csn_cfg[i*DW +: DW] = DW'(i + 3);
            del_csp_cfg[i*DW +: DW] = DW'(i + 5);
        end
        test_reset();
        test_single();
        test_round_robin();
        test_gap();
        test_drop();
        test_reset_mid();
`ifdef SPI_TX_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
